// File: rtl/pc_fetch_stage.sv
// pc_fetch_stage
//   PC register and instruction-fetch stage of an RV32I pipeline. It sequences
//   one word fetch at a time over a req/gnt/rvalid instruction-memory port and
//   fills the IF/ID register. A one-entry skid buffer absorbs a returning word
//   while decode is stalled. Redirects from the branch-resolve stage flush IF/ID
//   and the skid, and they discard any fetch that is still in flight.
//
// Ports
//   clk_i, rst_i         clock (rising edge) and synchronous active-high reset
//   pc_mux_sel_i         redirect request; pc_taken_i is the redirect target
//   stall_i              hazard stall: hold the IF/ID contents
//   imem_req_o/addr_o    fetch request and word-aligned address
//   imem_gnt_i           request accepted this cycle
//   imem_rvalid_i/rdata  returned instruction word, one per grant
//   if_pc_o/instr_o      IF/ID PC and instruction
//   if_valid_o           IF/ID holds a live instruction
//   fetch_misalign_o     (MISALIGN_CHK_EN only) one-cycle pulse when a redirect
//                        target is not word aligned
//
// Build option
//   MISALIGN_CHK_EN      adds fetch_misalign_o. Without this option, the low
//                        two target bits are cleared and no flag is raised.

module pc_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        pc_mux_sel_i,
    input  logic [31:0] pc_taken_i,
    input  logic        stall_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_instr_o,
    output logic        if_valid_o
`ifdef MISALIGN_CHK_EN
    ,
    output logic        fetch_misalign_o
`endif
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] inflight_pc_q, inflight_pc_d;   // address of the beat in flight
    logic        drop_q, drop_d;                 // discard the next rvalid
    logic        redirect_pend_q, redirect_pend_d;
    logic [31:0] target_q, target_d;             // latched target for pending redirect
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic        if_valid_q, if_valid_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic        misalign_q, misalign_d;

    logic [31:0] redirect_tgt;
    logic        if_accept;                      // IF/ID can take a new word

    assign redirect_tgt = pc_taken_i & 32'hFFFF_FFFC;
    assign if_accept    = !if_valid_q || !stall_i;

    always_comb begin
        // NOTE: every signal gets a default first, so no path can infer a latch.
        state_d         = state_q;
        fetch_pc_d      = fetch_pc_q;
        inflight_pc_d   = inflight_pc_q;
        drop_d          = drop_q;
        redirect_pend_d = redirect_pend_q;
        target_d        = target_q;
        if_pc_d         = if_pc_q;
        if_instr_d      = if_instr_q;
        if_valid_d      = if_valid_q;
        skid_valid_d    = skid_valid_q;
        skid_pc_d       = skid_pc_q;
        skid_instr_d    = skid_instr_q;
        misalign_d      = pc_mux_sel_i && (pc_taken_i[1:0] != 2'b00);

        // When decode is not stalled, it consumes the slot. The slot becomes a
        // bubble unless a word is loaded below.
        if (!stall_i) begin
            if_valid_d = 1'b0;
        end

        if (pc_mux_sel_i) begin
            // A redirect overrides a stall and flushes everything fetched so far.
            if_valid_d   = 1'b0;
            skid_valid_d = 1'b0;
            unique case (state_q)
                S_REQ: begin
                    if (imem_gnt_i) begin
                        // The beat granted now belongs to the old path.
                        state_d         = S_WAIT;
                        inflight_pc_d   = fetch_pc_q;
                        drop_d          = 1'b1;
                        redirect_pend_d = 1'b0;
                        fetch_pc_d      = redirect_tgt;
                    end else begin
                        // The request address must not change before the grant.
                        redirect_pend_d = 1'b1;
                        target_d        = redirect_tgt;
                    end
                end
                S_WAIT: begin
                    fetch_pc_d = redirect_tgt;
                    if (imem_rvalid_i) begin
                        state_d = S_REQ;
                        drop_d  = 1'b0;
                    end else begin
                        drop_d  = 1'b1;
                    end
                end
                S_HOLD: begin
                    state_d    = S_REQ;
                    fetch_pc_d = redirect_tgt;
                end
                default: state_d = S_REQ;
            endcase
        end else begin
            unique case (state_q)
                S_REQ: begin
                    if (imem_gnt_i) begin
                        state_d       = S_WAIT;
                        inflight_pc_d = fetch_pc_q;
                        if (redirect_pend_q) begin
                            drop_d          = 1'b1;
                            redirect_pend_d = 1'b0;
                            fetch_pc_d      = target_q;
                        end else begin
                            fetch_pc_d = fetch_pc_q + 32'd4;
                        end
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid_i) begin
                        state_d = S_REQ;
                        if (drop_q) begin
                            drop_d = 1'b0;
                        end else if (if_accept) begin
                            if_pc_d    = inflight_pc_q;
                            if_instr_d = imem_rdata_i;
                            if_valid_d = 1'b1;
                        end else begin
                            skid_valid_d = 1'b1;
                            skid_pc_d    = inflight_pc_q;
                            skid_instr_d = imem_rdata_i;
                            state_d      = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (if_accept) begin
                        if_pc_d      = skid_pc_q;
                        if_instr_d   = skid_instr_q;
                        if_valid_d   = 1'b1;
                        skid_valid_d = 1'b0;
                        state_d      = S_REQ;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the values from before this clock edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= S_REQ;
            fetch_pc_q      <= RESET_PC;
            inflight_pc_q   <= RESET_PC;
            drop_q          <= 1'b0;
            redirect_pend_q <= 1'b0;
            target_q        <= RESET_PC;
            if_pc_q         <= 32'h0;
            if_instr_q      <= NOP;
            if_valid_q      <= 1'b0;
            skid_valid_q    <= 1'b0;
            misalign_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            fetch_pc_q      <= fetch_pc_d;
            inflight_pc_q   <= inflight_pc_d;
            drop_q          <= drop_d;
            redirect_pend_q <= redirect_pend_d;
            target_q        <= target_d;
            if_pc_q         <= if_pc_d;
            if_instr_q      <= if_instr_d;
            if_valid_q      <= if_valid_d;
            skid_valid_q    <= skid_valid_d;
            misalign_q      <= misalign_d;
        end
    end

    // NOTE: the skid payload is not reset. Nothing reads it unless
    // skid_valid_q is set, so resetting it would only cost reset fan-out.
    always_ff @(posedge clk_i) begin
        skid_pc_q    <= skid_pc_d;
        skid_instr_q <= skid_instr_d;
    end

    assign imem_req_o  = (state_q == S_REQ) && !rst_i;
    assign imem_addr_o = fetch_pc_q;
    assign if_pc_o     = if_pc_q;
    assign if_instr_o  = if_instr_q;
    assign if_valid_o  = if_valid_q;

`ifdef MISALIGN_CHK_EN
    assign fetch_misalign_o = misalign_q;
`else
    logic unused_misalign;
    assign unused_misalign = misalign_q;
`endif

endmodule

// File: tb/tb_pc_fetch_stage.sv
// tb_pc_fetch_stage
//   Directed bench for pc_fetch_stage. Inputs change right after a falling
//   edge and the DUT samples them at the next rising edge. Outputs are checked
//   at the falling edge that follows. Instruction words are derived from the
//   fetch address, so each delivered word identifies the address it came from.

module tb_pc_fetch_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        pc_mux_sel_i;
    logic [31:0] pc_taken_i;
    logic        stall_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] if_pc_o;
    logic [31:0] if_instr_o;
    logic        if_valid_o;
`ifdef MISALIGN_CHK_EN
    logic        fetch_misalign_o;
`endif

    int n_cmp = 0;
    int n_err = 0;

    pc_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .pc_mux_sel_i  (pc_mux_sel_i),
        .pc_taken_i    (pc_taken_i),
        .stall_i       (stall_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .if_pc_o       (if_pc_o),
        .if_instr_o    (if_instr_o),
        .if_valid_o    (if_valid_o)
`ifdef MISALIGN_CHK_EN
        ,
        .fetch_misalign_o (fetch_misalign_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drive the memory inputs for one rising edge, then return at the next falling edge.
    task automatic step(input logic g, input logic rv, input logic [31:0] rd);
        imem_gnt_i    = g;
        imem_rvalid_i = rv;
        imem_rdata_i  = rd;
        @(negedge clk_i);
    endtask

    task automatic redirect(input logic [31:0] tgt);
        pc_mux_sel_i = 1'b1;
        pc_taken_i   = tgt;
    endtask

    // One normal fetch: grant now, return the data one cycle later.
    // Afterwards, IF/ID holds {a, instr_of(a)}.
    task automatic fetch(input logic [31:0] a, input string tag);
        check({tag, "_addr"}, imem_addr_o, a);
        step(1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, instr_of(a));
        check({tag, "_vld"}, {31'b0, if_valid_o}, 32'd1);
        check({tag, "_pc"}, if_pc_o, a);
        check({tag, "_ins"}, if_instr_o, instr_of(a));
    endtask

    initial begin
        rst_i         = 1'b1;
        pc_mux_sel_i  = 1'b0;
        pc_taken_i    = 32'h0;
        stall_i       = 1'b0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        repeat (2) @(negedge clk_i);

        // Reset state
        check("rst_req", {31'b0, imem_req_o}, 32'd0);
        check("rst_vld", {31'b0, if_valid_o}, 32'd0);
        check("rst_pc", if_pc_o, 32'h0);
        check("rst_ins", if_instr_o, 32'h0000_0013);
        check("rst_addr", imem_addr_o, 32'h0);
`ifdef MISALIGN_CHK_EN
        check("rst_mis", {31'b0, fetch_misalign_o}, 32'd0);
`endif
        rst_i = 1'b0;
        step(1'b0, 1'b0, 32'h0);
        check("t1_req", {31'b0, imem_req_o}, 32'd1);

        // 1: straight-line fetch
        fetch(32'h0, "t1_0");
        fetch(32'h4, "t1_4");

        // 2: stall with IF/ID full; the word goes to the skid, then drains in order
        stall_i = 1'b1;
        check("t2_addr", imem_addr_o, 32'h8);
        step(1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, instr_of(32'h8));
        check("t2_hold_req", {31'b0, imem_req_o}, 32'd0);
        check("t2_hold_pc", if_pc_o, 32'h4);
        check("t2_hold_vld", {31'b0, if_valid_o}, 32'd1);
        step(1'b0, 1'b0, 32'h0);
        check("t2_hold2_req", {31'b0, imem_req_o}, 32'd0);
        stall_i = 1'b0;
        step(1'b0, 1'b0, 32'h0);
        check("t2_drain_pc", if_pc_o, 32'h8);
        check("t2_drain_ins", if_instr_o, instr_of(32'h8));
        check("t2_drain_vld", {31'b0, if_valid_o}, 32'd1);
        check("t2_req", {31'b0, imem_req_o}, 32'd1);
        fetch(32'hC, "t2_c");

        // 3: redirect while waiting for 0x10; the returning word is dropped
        check("t3_addr", imem_addr_o, 32'h10);
        step(1'b1, 1'b0, 32'h0);
        redirect(32'h100);
        step(1'b0, 1'b0, 32'h0);
        pc_mux_sel_i = 1'b0;
        check("t3_vld_n1", {31'b0, if_valid_o}, 32'd0);
        step(1'b0, 1'b1, instr_of(32'h10));
        check("t3_drop_vld", {31'b0, if_valid_o}, 32'd0);
        check("t3_req", {31'b0, imem_req_o}, 32'd1);
        fetch(32'h100, "t3_tgt");

        // 4: redirect with the request ungranted; the address holds until the grant
        redirect(32'h200);
        step(1'b0, 1'b0, 32'h0);
        pc_mux_sel_i = 1'b0;
        check("t4_vld_n1", {31'b0, if_valid_o}, 32'd0);
        check("t4_addr_a", imem_addr_o, 32'h104);
        step(1'b0, 1'b0, 32'h0);
        check("t4_addr_b", imem_addr_o, 32'h104);
        step(1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, instr_of(32'h104));
        check("t4_drop_vld", {31'b0, if_valid_o}, 32'd0);
        fetch(32'h200, "t4_tgt");

        // 5: redirect, stall and a deliverable rvalid all in one cycle
        stall_i = 1'b1;
        step(1'b1, 1'b0, 32'h0);
        redirect(32'h300);
        step(1'b0, 1'b1, instr_of(32'h204));
        pc_mux_sel_i = 1'b0;
        stall_i      = 1'b0;
        check("t5_vld_n1", {31'b0, if_valid_o}, 32'd0);
        check("t5_req", {31'b0, imem_req_o}, 32'd1);
        fetch(32'h300, "t5_tgt");

        // Back-to-back redirects: the last one wins, and its low bits are cleared
        redirect(32'h400);
        step(1'b0, 1'b0, 32'h0);
        redirect(32'h502);
        step(1'b0, 1'b0, 32'h0);
        pc_mux_sel_i = 1'b0;
`ifdef MISALIGN_CHK_EN
        check("b2b_mis", {31'b0, fetch_misalign_o}, 32'd1);
`endif
        check("b2b_addr_hold", imem_addr_o, 32'h304);
        step(1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, instr_of(32'h304));
        check("b2b_drop_vld", {31'b0, if_valid_o}, 32'd0);
        fetch(32'h500, "b2b_tgt");

        // Address wrap at the top of the address space
        redirect(32'hFFFF_FFFC);
        step(1'b1, 1'b0, 32'h0);
        pc_mux_sel_i = 1'b0;
        step(1'b0, 1'b1, instr_of(32'h504));
        fetch(32'hFFFF_FFFC, "wrap_top");
        check("wrap_addr", imem_addr_o, 32'h0);

        // 7: misaligned target while waiting; the address is forced to 0x100
        step(1'b1, 1'b0, 32'h0);
        redirect(32'h102);
        step(1'b0, 1'b0, 32'h0);
        pc_mux_sel_i = 1'b0;
`ifdef MISALIGN_CHK_EN
        check("t7_mis_n1", {31'b0, fetch_misalign_o}, 32'd1);
`endif
        step(1'b0, 1'b1, instr_of(32'h0));
`ifdef MISALIGN_CHK_EN
        check("t7_mis_n2", {31'b0, fetch_misalign_o}, 32'd0);
`endif
        check("t7_addr", imem_addr_o, 32'h100);

        // 6: reset in S_WAIT; a stale rvalid after reset is ignored
        step(1'b1, 1'b0, 32'h0);
        rst_i = 1'b1;
        step(1'b0, 1'b0, 32'h0);
        check("t6_rst_req", {31'b0, imem_req_o}, 32'd0);
        check("t6_rst_ins", if_instr_o, 32'h0000_0013);
        rst_i = 1'b0;
        step(1'b0, 1'b1, 32'hDEAD_BEEF);
        check("t6_stale_vld", {31'b0, if_valid_o}, 32'd0);
        check("t6_req", {31'b0, imem_req_o}, 32'd1);
        fetch(32'h0, "t6_first");

        // Redirect in S_HOLD: the skid is cleared and nothing stale drains later
        stall_i = 1'b1;
        step(1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, instr_of(32'h4));
        check("hold_req", {31'b0, imem_req_o}, 32'd0);
        redirect(32'h600);
        step(1'b0, 1'b0, 32'h0);
        pc_mux_sel_i = 1'b0;
        stall_i      = 1'b0;
        check("hold_vld_n1", {31'b0, if_valid_o}, 32'd0);
        check("hold_addr", imem_addr_o, 32'h600);
        step(1'b0, 1'b0, 32'h0);
        check("hold_no_drain", {31'b0, if_valid_o}, 32'd0);
        fetch(32'h600, "hold_tgt");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
